// File: rtl/ball_locator_axil_regfile.sv
`default_nettype none
// ============================================================================
// Module   : ball_locator_axil_regfile
// Purpose  : AXI4-Lite slave with byte-writable control registers and
//            coherently captured read-only status shadows.
// Revision : 1.0  initial release
// ============================================================================
module ball_locator_axil_regfile #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_NUM_RW_REGS      = 4,
    parameter int C_NUM_RO_REGS      = 4
) (
    input  logic                                S_AXI_ACLK,
    input  logic                                S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
    input  logic [2:0]                          S_AXI_AWPROT,
    input  logic                                S_AXI_AWVALID,
    output logic                                S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
    input  logic                                S_AXI_WVALID,
    output logic                                S_AXI_WREADY,
    output logic [1:0]                          S_AXI_BRESP,
    output logic                                S_AXI_BVALID,
    input  logic                                S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
    input  logic [2:0]                          S_AXI_ARPROT,
    input  logic                                S_AXI_ARVALID,
    output logic                                S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
    output logic [1:0]                          S_AXI_RRESP,
    output logic                                S_AXI_RVALID,
    input  logic                                S_AXI_RREADY,
    output logic [32*C_NUM_RW_REGS-1:0]         rw_regs_o,
    output logic [C_NUM_RW_REGS-1:0]            wr_pulse_o,
    input  logic [32*C_NUM_RO_REGS-1:0]         ro_regs_i,
    input  logic                                ro_update_i
);

    localparam int         c_idx_w       = C_S_AXI_ADDR_WIDTH - 2;
    localparam int         c_strb_w      = C_S_AXI_DATA_WIDTH / 8;
    localparam int         c_ro_n        = (C_NUM_RO_REGS > 0) ? C_NUM_RO_REGS : 1;
    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    logic                          r_aw_held;
    logic [c_idx_w-1:0]            r_aw_idx;
    logic                          r_w_held;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_w_data;
    logic [c_strb_w-1:0]           r_w_strb;
    logic                          r_bvalid;
    logic [1:0]                    r_bresp;
    logic                          r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]                    r_rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rw [C_NUM_RW_REGS];
    logic [C_S_AXI_DATA_WIDTH-1:0] r_ro [c_ro_n];
    logic [C_NUM_RW_REGS-1:0]      r_wr_pulse;

    logic                          w_awready;
    logic                          w_wready;
    logic                          w_arready;
    logic                          w_aw_hs;
    logic                          w_w_hs;
    logic                          w_ar_hs;
    logic                          w_commit;
    logic [c_idx_w:0]              w_wr_idx;
    logic [c_idx_w:0]              w_rd_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_wr_data;
    logic [c_strb_w-1:0]           w_wr_strb;
    logic [C_NUM_RW_REGS-1:0]      w_wr_sel;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]                    w_rd_resp;
    logic                          w_unused;

    // Readies are qualified by reset so they read as zero while it is held.
    assign w_awready = S_AXI_ARESETN && !r_aw_held && !r_bvalid;
    assign w_wready  = S_AXI_ARESETN && !r_w_held && !r_bvalid;
    assign w_arready = S_AXI_ARESETN && !r_rvalid;

    assign w_aw_hs = S_AXI_AWVALID && w_awready;
    assign w_w_hs  = S_AXI_WVALID && w_wready;
    assign w_ar_hs = S_AXI_ARVALID && w_arready;

    assign w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs) && !r_bvalid;
    assign w_wr_idx  = {1'b0, (r_aw_held ? r_aw_idx : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2])};
    assign w_wr_data = r_w_held ? r_w_data : S_AXI_WDATA;
    assign w_wr_strb = r_w_held ? r_w_strb : S_AXI_WSTRB;
    assign w_rd_idx  = {1'b0, S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]};

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        w_wr_sel = '0;
        for (int k = 0; k < C_NUM_RW_REGS; k++) begin
            w_wr_sel[k] = w_commit && (w_wr_idx == (c_idx_w + 1)'(k));
        end
    end

    // Anything that matches no register falls through to zero data with SLVERR.
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = c_resp_slverr;
        for (int k = 0; k < C_NUM_RW_REGS; k++) begin
            if (w_rd_idx == (c_idx_w + 1)'(k)) begin
                w_rd_data = r_rw[k];
                w_rd_resp = c_resp_okay;
            end
        end
        for (int k = 0; k < C_NUM_RO_REGS; k++) begin
            if (w_rd_idx == (c_idx_w + 1)'(C_NUM_RW_REGS + k)) begin
                w_rd_data = r_ro[k];
                w_rd_resp = c_resp_okay;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_resp_okay;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= c_resp_okay;
        end else begin
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= (|w_wr_sel) ? c_resp_okay : c_resp_slverr;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_w_data <= S_AXI_WDATA;
                    r_w_strb <= S_AXI_WSTRB;
                end
                if (r_bvalid && S_AXI_BREADY) begin
                    r_bvalid <= 1'b0;
                end
            end

            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_resp;
            end else if (r_rvalid && S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // The pulse fires on every committed RW write, including an all-zero strobe.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_wr_pulse <= '0;
            for (int k = 0; k < C_NUM_RW_REGS; k++) begin
                r_rw[k] <= '0;
            end
        end else begin
            r_wr_pulse <= w_wr_sel;
            for (int k = 0; k < C_NUM_RW_REGS; k++) begin
                for (int b = 0; b < c_strb_w; b++) begin
                    if (w_wr_sel[k] && w_wr_strb[b]) begin
                        r_rw[k][8*b +: 8] <= w_wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    generate
        if (C_NUM_RO_REGS > 0) begin : g_ro
            always_ff @(posedge S_AXI_ACLK) begin
                for (int k = 0; k < C_NUM_RO_REGS; k++) begin
                    if (!S_AXI_ARESETN) begin
                        r_ro[k] <= '0;
                    end else if (ro_update_i) begin
                        r_ro[k] <= ro_regs_i[32*k +: 32];
                    end
                end
            end
        end else begin : g_no_ro
            assign r_ro[0] = '0;
        end
    endgenerate

    generate
        for (genvar k = 0; k < C_NUM_RW_REGS; k++) begin : g_rw_out
            assign rw_regs_o[32*k +: 32] = r_rw[k];
        end
    endgenerate

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign wr_pulse_o    = r_wr_pulse;

endmodule
`default_nettype wire

// File: tb/tb_ball_locator_axil_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_ball_locator_axil_regfile
// Purpose  : Directed and randomized checks of the AXI-Lite register file
//            against a cycle-level behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ball_locator_axil_regfile;

    logic         clk = 1'b0;
    logic         rstn;
    logic [5:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic [127:0] ro_regs;
    logic         ro_update;

    logic         AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]   BRESP, RRESP;
    logic [31:0]  RDATA;
    logic [127:0] rw_regs;
    logic [3:0]   wr_pulse;

    always #5 clk = ~clk;

    ball_locator_axil_regfile dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rstn),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (WREADY),
        .S_AXI_BRESP  (BRESP),
        .S_AXI_BVALID (BVALID),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA  (RDATA),
        .S_AXI_RRESP  (RRESP),
        .S_AXI_RVALID (RVALID),
        .S_AXI_RREADY (rready),
        .rw_regs_o    (rw_regs),
        .wr_pulse_o   (wr_pulse),
        .ro_regs_i    (ro_regs),
        .ro_update_i  (ro_update)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt [4];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: state as it must look after the most recent edge.
    bit          m_started = 1'b0;
    logic [31:0] m_rw [4];
    logic [31:0] m_ro [4];
    logic        m_aw_held, m_w_held, m_bvalid, m_rvalid;
    logic [5:0]  m_aw_addr;
    logic [31:0] m_w_data, m_rdata;
    logic [3:0]  m_w_strb, m_pulse;
    logic [1:0]  m_bresp, m_rresp;
    logic        e_awready, e_wready, e_arready, e_commit;
    int          ri, wi;
    logic [31:0] wd;
    logic [3:0]  ws;

    always @(negedge clk) begin
        e_awready = rstn && !m_aw_held && !m_bvalid;
        e_wready  = rstn && !m_w_held && !m_bvalid;
        e_arready = rstn && !m_rvalid;
        if (m_started) begin
            chk("awready", AWREADY, e_awready);
            chk("wready", WREADY, e_wready);
            chk("arready", ARREADY, e_arready);
            chk("bvalid", BVALID, m_bvalid);
            chk("rvalid", RVALID, m_rvalid);
            if (m_bvalid) chk("bresp", BRESP, m_bresp);
            if (m_rvalid) begin
                chk("rdata", RDATA, m_rdata);
                chk("rresp", RRESP, m_rresp);
            end
            chk("rw_regs", rw_regs, {m_rw[3], m_rw[2], m_rw[1], m_rw[0]});
            chk("wr_pulse", wr_pulse, m_pulse);
            for (int k = 0; k < 4; k++) pulse_cnt[k] += int'(wr_pulse[k]);
        end

        if (!rstn) begin
            m_aw_held = 0; m_w_held = 0; m_bvalid = 0; m_rvalid = 0;
            m_aw_addr = 0; m_w_data = 0; m_w_strb = 0; m_pulse = 0;
            m_bresp = 0; m_rresp = 0; m_rdata = 0;
            for (int k = 0; k < 4; k++) begin m_rw[k] = 0; m_ro[k] = 0; end
            m_started = 1'b1;
        end else begin
            // Read sees register and shadow contents from before this edge.
            if (arvalid && e_arready) begin
                ri = int'(araddr[5:2]);
                if (ri < 4)      begin m_rdata = m_rw[ri];   m_rresp = 2'b00; end
                else if (ri < 8) begin m_rdata = m_ro[ri-4]; m_rresp = 2'b00; end
                else             begin m_rdata = 0;          m_rresp = 2'b10; end
                m_rvalid = 1;
            end else if (m_rvalid && rready) begin
                m_rvalid = 0;
            end

            e_commit = (m_aw_held || (awvalid && e_awready)) &&
                       (m_w_held || (wvalid && e_wready)) && !m_bvalid;
            m_pulse = 0;
            if (m_bvalid && bready) m_bvalid = 0;
            if (e_commit) begin
                wi = int'(m_aw_held ? m_aw_addr[5:2] : awaddr[5:2]);
                wd = m_w_held ? m_w_data : wdata;
                ws = m_w_held ? m_w_strb : wstrb;
                if (wi < 4) begin
                    for (int b = 0; b < 4; b++) if (ws[b]) m_rw[wi][8*b +: 8] = wd[8*b +: 8];
                    m_pulse[wi] = 1'b1;
                    m_bresp = 2'b00;
                end else begin
                    m_bresp = 2'b10;
                end
                m_bvalid = 1; m_aw_held = 0; m_w_held = 0;
            end else begin
                if (awvalid && e_awready) begin m_aw_held = 1; m_aw_addr = awaddr; end
                if (wvalid && e_wready) begin m_w_held = 1; m_w_data = wdata; m_w_strb = wstrb; end
            end

            if (ro_update) for (int k = 0; k < 4; k++) m_ro[k] = ro_regs[32*k +: 32];
        end
    end

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_hs, w_hs, done = 0;
        awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1; bready = 1; resp = 2'bxx;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            aw_hs = awvalid && AWREADY;
            w_hs  = wvalid && WREADY;
            if (BVALID && bready) begin resp = BRESP; done = 1; end
            @(posedge clk); #1;
            if (aw_hs) awvalid = 0;
            if (w_hs) wvalid = 0;
        end
        awvalid = 0; wvalid = 0;
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL write_timeout addr %0h: got no BVALID, required one within 50 cycles", a);
        end
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
        bit ar_hs, done = 0;
        araddr = a; arvalid = 1; rready = 1; d = 'x; r = 'x;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            ar_hs = arvalid && ARREADY;
            if (RVALID && rready) begin d = RDATA; r = RRESP; done = 1; end
            @(posedge clk); #1;
            if (ar_hs) arvalid = 0;
        end
        arvalid = 0;
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL read_timeout addr %0h: got no RVALID, required one within 50 cycles", a);
        end
    endtask

    logic [31:0] rd;
    logic [1:0]  rr, br;
    bit          ah, wh;
    int          bcnt, t_bv;

    initial begin
        rstn = 0; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = 0; wstrb = 0; ro_regs = 0; ro_update = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rw_regs", rw_regs, 128'h0);
        chk("reset_awready", AWREADY, 1'b0);
        chk("reset_bvalid", BVALID, 1'b0);
        chk("reset_rdata", RDATA, 32'h0);
        @(posedge clk); #1;
        rstn = 1;

        // Basic write then read-back of every RW register.
        for (int k = 0; k < 4; k++) pulse_cnt[k] = 0;
        for (int k = 0; k < 4; k++) begin
            axi_write(6'(4*k), 32'(k+1), 4'hF, br);
            chk("wr_basic_bresp", br, 2'b00);
        end
        for (int k = 0; k < 4; k++) chk("wr_pulse_count", pulse_cnt[k], 1);
        for (int k = 0; k < 4; k++) begin
            axi_read(6'(4*k), rd, rr);
            chk("rd_basic_data", rd, 32'(k+1));
            chk("rd_basic_rresp", rr, 2'b00);
        end

        // Byte strobes.
        axi_write(6'h04, 32'hAABBCCDD, 4'hF, br);
        axi_write(6'h04, 32'h11223344, 4'b0101, br);
        axi_read(6'h04, rd, rr);
        chk("strobe_merge", rd, 32'hAA22CC44);

        // W ahead of AW by two cycles, BREADY held off for five cycles.
        bcnt = 0; t_bv = -1;
        wdata = 32'h5A5A0001; wstrb = 4'hF; wvalid = 1; bready = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            ah = awvalid && AWREADY;
            wh = wvalid && WREADY;
            if (BVALID && t_bv < 0) t_bv = c;
            if (BVALID && bready) bcnt++;
            @(posedge clk); #1;
            if (ah) awvalid = 0;
            if (wh) wvalid = 0;
            if (c == 1) begin awaddr = 6'h08; awvalid = 1; end
            bready = (t_bv >= 0) && (c >= t_bv + 5);
        end
        bready = 1;
        chk("b_handshake_count", bcnt, 1);
        axi_read(6'h08, rd, rr);
        chk("late_aw_data", rd, 32'h5A5A0001);

        // Status capture is a snapshot, not a live view.
        ro_regs = {32'h0000_0044, 32'h0000_0033, 32'h0000_0078, 32'h0000_00F0};
        ro_update = 1;
        @(posedge clk); #1;
        ro_update = 0;
        ro_regs = {4{32'h1234_5678}};
        axi_read(6'h10, rd, rr);
        chk("ro_x", rd, 32'h0000_00F0);
        axi_read(6'h14, rd, rr);
        chk("ro_y", rd, 32'h0000_0078);

        // Illegal targets.
        axi_write(6'h10, 32'h0000DEAD, 4'hF, br);
        chk("wr_ro_bresp", br, 2'b10);
        axi_write(6'h3C, 32'h0000DEAD, 4'hF, br);
        chk("wr_oor_bresp", br, 2'b10);
        axi_read(6'h3C, rd, rr);
        chk("rd_oor_data", rd, 32'h0);
        chk("rd_oor_rresp", rr, 2'b10);
        axi_read(6'h10, rd, rr);
        chk("ro_after_wr", rd, 32'h0000_00F0);

        // Read held off by RREADY, with a reset pulse during the hold.
        araddr = 6'h04; arvalid = 1; rready = 0;
        for (int i = 0; i < 10 && arvalid; i++) begin
            @(negedge clk);
            ah = arvalid && ARREADY;
            @(posedge clk); #1;
            if (ah) arvalid = 0;
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("r_hold_valid", RVALID, (c < 3) ? 1'b1 : 1'b0);
            if (c < 3) chk("r_hold_data", RDATA, 32'hAA22CC44);
            @(posedge clk); #1;
            if (c == 1) rstn = 0;
            if (c == 2) rstn = 1;
        end
        rready = 1;
        for (int k = 0; k < 8; k++) begin
            axi_read(6'(4*k), rd, rr);
            chk("post_reset_zero", rd, 32'h0);
        end

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rstn      = ($urandom_range(0, 299) != 0);
            awvalid   = $urandom_range(0, 1) == 1;
            awaddr    = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 31));
            awprot    = 3'($urandom);
            wvalid    = $urandom_range(0, 1) == 1;
            wdata     = $urandom;
            wstrb     = 4'($urandom_range(0, 15));
            bready    = ($urandom_range(0, 3) != 0);
            arvalid   = $urandom_range(0, 1) == 1;
            araddr    = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 31));
            arprot    = 3'($urandom);
            rready    = ($urandom_range(0, 3) != 0);
            ro_update = ($urandom_range(0, 7) == 0);
            ro_regs   = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end

        rstn = 1; awvalid = 0; wvalid = 0; arvalid = 0; ro_update = 0;
        bready = 1; rready = 1;
        repeat (5) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
